uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the single-byte UART receiver. It supports configurable data width, optional parity, one or two stop bits and a configurable oversampling ratio. It uses majority-vote bit sampling and detects framing errors, parity errors and line breaks. Received words are buffered in a small FIFO drained through a valid/ready handshake, so the consumer need not respond within one frame time.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; even, >= 8
DATA_BITS, 8, data bits per frame; 5..9
PARITY_EN, 0, 1 = parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
data_out  output  DATA_BITS  FIFO head data word, LSB = first bit received
data_valid  output  1  FIFO non-empty; data_out, frame_err and parity_err are valid
data_ready  input  1  consumer accepts head entry when data_valid & data_ready
frame_err  output  1  head entry had a stop bit sampled low
parity_err  output  1  head entry failed parity; always 0 when PARITY_EN = 0
overrun  output  1  one-cycle pulse: a completed frame was dropped because the FIFO was full
break_det  output  1  one-cycle pulse: break condition detected
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (reset = 0, asynchronous) clears the FSM to IDLE, counters and the FIFO.
- During reset all outputs are 0; both synchronizer flops are set to 1.
- A reset mid-frame discards the partial frame.
- rx passes through a 2-flop synchronizer (rx_s); all references below are to rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: a 1 -> 0 transition of rx_s moves to START and clears the bit-clock counter.
- Sample point is counter = CLKS_PER_BIT/2 - 1 within each bit period.
- Bit value = majority of rx_s at counter = mid-1, mid and mid+1.
- START: if the voted start bit is 1, return to IDLE (glitch rejection). Otherwise proceed to DATA at the end of the bit period.
- DATA: shift DATA_BITS voted bits, LSB first. Then go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: parity_err_int = (XOR of data bits ^ parity bit) != PARITY_ODD.
- STOP: sample STOP_BITS stop bits; frame_err_int = 1 if any voted stop bit is 0.
- The frame completes at the sample point of the final stop bit, not at the end of that bit period. The FSM returns to IDLE immediately, allowing back-to-back frames.
- Break: all data bits 0, parity bit (if enabled) 0, and first stop bit 0.
  - break_det pulses for 1 cycle and nothing is written to the FIFO.
  - The FSM enters BREAK_WAIT and stays until rx_s = 1, then goes to IDLE.
- On frame completion (non-break), push {data, frame_err_int, parity_err_int}:
  - if FIFO not full: written; data_valid visible the next cycle.
  - if FIFO full: entry dropped, overrun pulses 1 cycle, FIFO contents unchanged.
- Pop occurs when data_valid & data_ready.
- Simultaneous push and pop on a full FIFO: the pop frees space, the push succeeds and no overrun occurs.
- fifo_count stays between 0 and FIFO_DEPTH inclusive; read and write pointers wrap modulo FIFO_DEPTH.
- data_out, frame_err and parity_err are combinational from the FIFO head; they read 0 when the FIFO is empty.
- Latency, rx falling edge to data_valid: 2 + (DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles. This is 155 cycles for the 8N1, CLKS_PER_BIT = 16 configuration.

Test Plan:
1. Defaults, 10 ns clk, bit = 160 ns; send 0xA5 (8N1), data_ready = 1 → data_valid 1 cycle with data_out = 0xA5, frame_err = 0, parity_err = 0, 155 cycles after the start edge.
2. PARITY_EN = 1, PARITY_ODD = 0:
   - send 0x3C with parity 0 → parity_err = 0.
   - send 0x3C with parity 1 → parity_err = 1, data_out = 0x3C.
3. data_ready = 0, send 5 frames 0x01..0x05 with FIFO_DEPTH = 4 → fifo_count = 4, overrun pulses once on frame 5. Draining then yields 0x01, 0x02, 0x03, 0x04 in order.
4. Send 0x55 with stop bit driven 0 → frame_err = 1, data_out = 0x55. Then hold rx low for 20 bit times → break_det pulses once and no FIFO write occurs. Release rx, send 0x81 → received correctly.
5. Glitches and mid-frame reset:
   - rx low for 3 cycles in IDLE → no frame, FSM stays IDLE.
   - 1-cycle glitch inside the 0xF0 data bit 4 sample window → majority vote still yields 0xF0.
   - assert reset mid-data of a frame → outputs 0, fifo_count = 0; the next 0x5A frame is received correctly.
6. Back-to-back 0xAA, 0x55 with zero idle gap, and STOP_BITS = 2 run with 0xC3 → all bytes received, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with majority-vote bit sampling,
// parity/framing/break detection and a receive FIFO drained by valid/ready.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   rx          serial line (idle high), asynchronous to clk
//   data_out    FIFO head data word, LSB = first bit received (0 when empty)
//   data_valid  FIFO non-empty
//   data_ready  consumer pops the head when data_valid & data_ready
//   frame_err   head entry had a stop bit sampled low (0 when empty)
//   parity_err  head entry failed parity (0 when empty)
//   overrun     1-cycle pulse: completed frame dropped, FIFO full
//   break_det   1-cycle pulse: break condition detected
//   fifo_count  occupied FIFO entries
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  output logic                        break_det,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned MID    = CLKS_PER_BIT / 2 - 1;
  localparam logic        PAR_EN_C = (PARITY_EN != 0);
  localparam logic        ODD_C    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_e;

  // Synchronizer and receive FSM registers
  logic                 rx_s1_q, rx_s_q;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           vote_q, vote_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 break_q, break_d;
  logic                 overrun_q, overrun_d;

  // FIFO registers
  logic [DATA_BITS-1:0] mem_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_fe_q, mem_pe_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;

  logic cnt_last_c, sample_c, bit_c, push_c, push_fe_c;
  logic pop_c, full_c, push_ok_c;

  assign cnt_last_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  // Vote completes one cycle after the nominal sample point, once all three taps exist
  assign sample_c   = (cnt_q == CNT_W'(MID + 1));
  assign bit_c      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
  assign push_fe_c  = fe_q | ~bit_c;

  // Receive FSM next-state and datapath
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_last_c ? '0 : cnt_q + CNT_W'(1);
    vote_d     = vote_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    fe_d       = fe_q;
    pe_d       = pe_q;
    break_d    = 1'b0;
    push_c     = 1'b0;

    if (cnt_q == CNT_W'(MID - 1)) vote_d[0] = rx_s_q;
    if (cnt_q == CNT_W'(MID))     vote_d[1] = rx_s_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        par_bit_d  = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
        // rx_s is about to fall: counter 0 lines up with the first low rx_s cycle
        if (rx_s_q && !rx_s1_q) state_d = S_START;
      end
      S_START: begin
        if (sample_c && bit_c) state_d = S_IDLE;
        else if (cnt_last_c)   state_d = S_DATA;
      end
      S_DATA: begin
        if (sample_c) begin
          shift_d   = {bit_c, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
        end
        if (cnt_last_c && bit_idx_q == IDX_W'(DATA_BITS)) begin
          state_d = PAR_EN_C ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample_c) begin
          par_bit_d = bit_c;
          pe_d      = ((^shift_q) ^ bit_c) != ODD_C;
        end
        if (cnt_last_c) state_d = S_STOP;
      end
      S_STOP: begin
        if (sample_c) begin
          if (!bit_c) fe_d = 1'b1;
          if (!stop_idx_q && !bit_c && shift_q == '0 && !par_bit_q) begin
            break_d = 1'b1;
            state_d = S_BREAK_WAIT;
          end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      S_BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control; a pop in the same cycle frees room for a push into a full FIFO
  always_comb begin
    pop_c     = data_valid & data_ready;
    full_c    = (count_q == FCNT_W'(FIFO_DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    overrun_d = push_c & full_c & ~pop_c;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_c);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_c);
    count_d   = count_q + FCNT_W'(push_ok_c) - FCNT_W'(pop_c);
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      vote_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      break_q    <= 1'b0;
      overrun_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_fe_q   <= '0;
      mem_pe_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_data_q[i] <= '0;
    end else begin
      rx_s1_q    <= rx;
      rx_s_q     <= rx_s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vote_q     <= vote_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      break_q    <= break_d;
      overrun_q  <= overrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push_ok_c) begin
        mem_data_q[wr_ptr_q] <= shift_q;
        mem_fe_q[wr_ptr_q]   <= push_fe_c;
        mem_pe_q[wr_ptr_q]   <= pe_q;
      end
    end
  end

  // Head-of-FIFO view, forced to zero when empty
  assign data_valid = (count_q != '0);
  assign data_out   = data_valid ? mem_data_q[rd_ptr_q] : '0;
  assign frame_err  = data_valid & mem_fe_q[rd_ptr_q];
  assign parity_err = data_valid & mem_pe_q[rd_ptr_q];
  assign overrun    = overrun_q;
  assign break_det  = break_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: 8N1, u1: 8E1, u2: 8N2
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic [7:0] d0, d1, d2;
  logic dv0, dv1, dv2, fe0, fe1, fe2, pe0, pe1, pe2;
  logic ov0, ov1, ov2, bk0, bk1, bk2;
  logic [2:0] fc0, fc1, fc2;

  uart_rx_param u0 (
    .clk(clk), .reset(rst_n), .rx(rx0), .data_out(d0), .data_valid(dv0),
    .data_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
    .break_det(bk0), .fifo_count(fc0)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(rst_n), .rx(rx1), .data_out(d1), .data_valid(dv1),
    .data_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
    .break_det(bk1), .fifo_count(fc1)
  );

  uart_rx_param #(.STOP_BITS(2)) u2 (
    .clk(clk), .reset(rst_n), .rx(rx2), .data_out(d2), .data_valid(dv2),
    .data_ready(rdy2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2),
    .break_det(bk2), .fifo_count(fc2)
  );

  // Pulse / first-valid monitors for u0, sampled on the falling edge
  int ov_cnt = 0, bk_cnt = 0, dv_hi = 0, dv_rise_cyc = 0;
  logic dv0_prev = 1'b0;
  logic [7:0] cap_d = '0;
  logic cap_fe = 1'b0, cap_pe = 1'b0;
  always @(negedge clk) begin
    if (ov0) ov_cnt = ov_cnt + 1;
    if (bk0) bk_cnt = bk_cnt + 1;
    if (dv0) dv_hi = dv_hi + 1;
    if (dv0 && !dv0_prev) begin
      dv_rise_cyc = cyc;
      cap_d  = d0;
      cap_fe = fe0;
      cap_pe = pe0;
    end
    dv0_prev = dv0;
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Frame bits LSB first: start, 8 data, optional parity, two stop slots, rest idle
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input bit pen,
                                          input logic p, input logic s0, input logic s1);
    logic [15:0] f;
    int idx;
    f = 16'hFFFF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    idx = 9;
    if (pen) begin
      f[9] = p;
      idx = 10;
    end
    f[idx] = s0;
    f[idx+1] = s1;
    return f;
  endfunction

  // Drive nbits frame bits, 16 cycles each; optionally invert one cycle of one bit
  task automatic send(input int inst, input logic [15:0] f, input int nbits,
                      input int gbit, input int gcyc);
    logic v;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 16; c++) begin
        v = f[i];
        if (i == gbit && c == gcyc) v = ~v;
        set_rx(inst, v);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pop0();
    rdy0 = 1'b1;
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
  endtask

  initial begin
    int t_start, dv_base, ov_base, bk_base;

    // Reset: all outputs zero
    wait_cyc(3);
    chk("rst_dv", 32'(dv0), 32'h0);
    chk("rst_data", 32'(d0), 32'h0);
    chk("rst_cnt", 32'(fc0), 32'h0);
    chk("rst_fe", 32'(fe0), 32'h0);
    chk("rst_pe", 32'(pe0), 32'h0);
    chk("rst_ov", 32'(ov0), 32'h0);
    chk("rst_bk", 32'(bk0), 32'h0);
    rst_n = 1'b1;
    wait_cyc(20);

    // 1: 0xA5 8N1, latency 155 cycles, valid for one cycle with ready high
    rdy0 = 1'b1;
    dv_base = dv_hi;
    t_start = cyc;
    send(0, mk_frame(8'hA5, 0, 1'b0, 1'b1, 1'b1), 10, -1, 0);
    wait_cyc(10);
    chk("t1_latency", 32'(dv_rise_cyc - t_start), 32'd155);
    chk("t1_valid_cycles", 32'(dv_hi - dv_base), 32'd1);
    chk("t1_data", 32'(cap_d), 32'hA5);
    chk("t1_fe", 32'(cap_fe), 32'h0);
    chk("t1_pe", 32'(cap_pe), 32'h0);
    chk("t1_empty", 32'(fc0), 32'h0);
    rdy0 = 1'b0;

    // 2: even parity on u1
    send(1, mk_frame(8'h3C, 1, 1'b0, 1'b1, 1'b1), 11, -1, 0);
    wait_cyc(4);
    chk("t2a_cnt", 32'(fc1), 32'd1);
    chk("t2a_data", 32'(d1), 32'h3C);
    chk("t2a_pe", 32'(pe1), 32'h0);
    rdy1 = 1'b1;
    wait_cyc(1);
    rdy1 = 1'b0;
    send(1, mk_frame(8'h3C, 1, 1'b1, 1'b1, 1'b1), 11, -1, 0);
    wait_cyc(4);
    chk("t2b_data", 32'(d1), 32'h3C);
    chk("t2b_pe", 32'(pe1), 32'h1);
    chk("t2b_fe", 32'(fe1), 32'h0);
    rdy1 = 1'b1;
    wait_cyc(1);
    rdy1 = 1'b0;
    chk("t2_empty", 32'(fc1), 32'h0);

    // 3: fill FIFO with 5 frames, overrun on the fifth, drain in order
    ov_base = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send(0, mk_frame(8'(i), 0, 1'b0, 1'b1, 1'b1), 10, -1, 0);
      wait_cyc(2);
      chk($sformatf("t3_cnt_%0d", i), 32'(fc0), (i > 4) ? 32'd4 : 32'(i));
      chk($sformatf("t3_ov_%0d", i), 32'(ov_cnt - ov_base), (i > 4) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t3_drain_%0d", i), 32'(d0), 32'(i));
      pop0();
    end
    chk("t3_empty", 32'(fc0), 32'h0);
    chk("t3_dv_empty", 32'(dv0), 32'h0);

    // 4: framing error, then break, then normal frame
    send(0, mk_frame(8'h55, 0, 1'b0, 1'b0, 1'b1), 10, -1, 0);
    wait_cyc(2);
    chk("t4_fe_data", 32'(d0), 32'h55);
    chk("t4_fe", 32'(fe0), 32'h1);
    chk("t4_fe_pe", 32'(pe0), 32'h0);
    pop0();
    rx0 = 1'b1;
    wait_cyc(32);
    bk_base = bk_cnt;
    rx0 = 1'b0;
    wait_cyc(320);
    chk("t4_break_once", 32'(bk_cnt - bk_base), 32'd1);
    chk("t4_break_nowrite", 32'(fc0), 32'h0);
    rx0 = 1'b1;
    wait_cyc(32);
    chk("t4_after_break", 32'(fc0), 32'h0);
    send(0, mk_frame(8'h81, 0, 1'b0, 1'b1, 1'b1), 10, -1, 0);
    wait_cyc(2);
    chk("t4_data_81", 32'(d0), 32'h81);
    chk("t4_fe_81", 32'(fe0), 32'h0);
    pop0();

    // 5: short idle glitch, in-window data glitch, mid-frame reset
    rx0 = 1'b0;
    wait_cyc(3);
    rx0 = 1'b1;
    wait_cyc(200);
    chk("t5_glitch_nocnt", 32'(fc0), 32'h0);
    chk("t5_glitch_nobrk", 32'(bk_cnt - bk_base), 32'd1);
    send(0, mk_frame(8'hF0, 0, 1'b0, 1'b1, 1'b1), 10, 5, 7);
    wait_cyc(2);
    chk("t5_vote_data", 32'(d0), 32'hF0);
    chk("t5_vote_cnt", 32'(fc0), 32'd1);
    send(0, mk_frame(8'h33, 0, 1'b0, 1'b1, 1'b1), 5, -1, 0);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("t5_rst_cnt", 32'(fc0), 32'h0);
    chk("t5_rst_dv", 32'(dv0), 32'h0);
    chk("t5_rst_data", 32'(d0), 32'h0);
    rx0 = 1'b1;
    rst_n = 1'b1;
    wait_cyc(32);
    send(0, mk_frame(8'h5A, 0, 1'b0, 1'b1, 1'b1), 10, -1, 0);
    wait_cyc(2);
    chk("t5_5a_cnt", 32'(fc0), 32'd1);
    chk("t5_5a_data", 32'(d0), 32'h5A);
    chk("t5_5a_fe", 32'(fe0), 32'h0);
    pop0();

    // 6: back-to-back frames, then two stop bits on u2
    send(0, mk_frame(8'hAA, 0, 1'b0, 1'b1, 1'b1), 10, -1, 0);
    send(0, mk_frame(8'h55, 0, 1'b0, 1'b1, 1'b1), 10, -1, 0);
    wait_cyc(2);
    chk("t6_b2b_cnt", 32'(fc0), 32'd2);
    chk("t6_b2b_first", 32'(d0), 32'hAA);
    chk("t6_b2b_fe1", 32'(fe0), 32'h0);
    pop0();
    chk("t6_b2b_second", 32'(d0), 32'h55);
    chk("t6_b2b_fe2", 32'(fe0), 32'h0);
    pop0();
    send(2, mk_frame(8'hC3, 0, 1'b0, 1'b1, 1'b1), 11, -1, 0);
    wait_cyc(2);
    chk("t6_2stop_data", 32'(d2), 32'hC3);
    chk("t6_2stop_fe", 32'(fe2), 32'h0);
    chk("t6_2stop_pe", 32'(pe2), 32'h0);
    rdy2 = 1'b1;
    wait_cyc(1);
    rdy2 = 1'b0;
    send(2, mk_frame(8'hC3, 0, 1'b0, 1'b1, 1'b0), 11, -1, 0);
    rx2 = 1'b1;
    wait_cyc(2);
    chk("t6_2stop_bad_data", 32'(d2), 32'hC3);
    chk("t6_2stop_bad_fe", 32'(fe2), 32'h1);
    chk("t6_overrun_total", 32'(ov_cnt - ov_base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
